// File: rtl/mvb_packer_pkg.sv
// Shared types and helpers for the MVB packer: item type, counter width and
// valid-mask helpers used by the top level and its timeout sub-block.
package mvb_packer_pkg;

    localparam int MAX_ITEMS      = 16;
    localparam int ITEMS_DEF      = 4;
    localparam int ITEM_WIDTH_DEF = 32;
    localparam int TIMEOUT_DEF    = 8;
    localparam int CNT_W          = $clog2(2*ITEMS_DEF+1);

    typedef logic [ITEM_WIDTH_DEF-1:0] item_t;

    function automatic int cnt_width(input int items);
        return $clog2(2*items+1);
    endfunction

    function automatic int unsigned popcount(input logic [MAX_ITEMS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_ITEMS; i++)
            n = n + 32'(v[i]);
        return n;
    endfunction

    function automatic logic [MAX_ITEMS-1:0] thermometer(input int n);
        logic [MAX_ITEMS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_ITEMS; i++)
            m[i] = (i < n);
        return m;
    endfunction

    // A mask is thermometer-coded exactly when it equals the mask of its own popcount.
    function automatic logic is_thermometer(input logic [MAX_ITEMS-1:0] v);
        return thermometer(int'(popcount(v))) == v;
    endfunction

endpackage

// File: rtl/mvb_packer_tmo.sv
// Saturating idle counter for the MVB packer; raises flush when a partial word
// has been sitting idle for TIMEOUT cycles.
module mvb_packer_tmo
    import mvb_packer_pkg::*;
#(
    parameter int ITEMS   = ITEMS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CW      = cnt_width(ITEMS_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cnt_next,
    input  logic          rx_items,
    input  logic          tx_fire,
    output logic          flush
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_nxt;
    logic          clr;

    always_comb begin
        clr = (cnt_next == '0) || (cnt_next >= CW'(ITEMS)) || rx_items || tx_fire;
        tmo_nxt = tmo_q;
        if (clr)
            tmo_nxt = '0;
        else if (tmo_q != TMAX)
            tmo_nxt = tmo_q + 1'b1;
    end

    // flush is registered from next-state values so it matches the current tmo/cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            flush <= 1'b0;
        end else begin
            tmo_q <= tmo_nxt;
            flush <= (tmo_nxt == TMAX) && (cnt_next != '0);
        end
    end

endmodule

// File: rtl/mvb_packer.sv
// MVB packer: merges compacted, partially filled MVB words into full ITEMS-wide
// words in order; a leftover partial word is flushed after an idle timeout.
module mvb_packer
    import mvb_packer_pkg::*;
#(
    parameter int ITEMS      = ITEMS_DEF,
    parameter int ITEM_WIDTH = ITEM_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [ITEMS*ITEM_WIDTH-1:0] RX_DATA,
    input  logic [ITEMS-1:0]            RX_VLD,
    input  logic                        RX_SRC_RDY,
    output logic                        RX_DST_RDY,
    output logic [ITEMS*ITEM_WIDTH-1:0] TX_DATA,
    output logic [ITEMS-1:0]            TX_VLD,
    output logic                        TX_SRC_RDY,
    input  logic                        TX_DST_RDY
);

    localparam int CW    = cnt_width(ITEMS);
    localparam int DEPTH = 2*ITEMS;
    localparam logic [CW-1:0] FULL = CW'(ITEMS);

    logic [ITEM_WIDTH-1:0] buf_q   [DEPTH];
    logic [ITEM_WIDTH-1:0] buf_nxt [DEPTH];
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_nxt;
    logic [CW-1:0]         n_in;
    logic [CW-1:0]         n_out;
    logic [CW-1:0]         n_avail;
    logic [CW-1:0]         base;
    logic                  flush;
    logic                  rx_fire;
    logic                  tx_fire;

    assign n_avail    = (cnt_q < FULL) ? cnt_q : FULL;
    assign TX_SRC_RDY = (cnt_q >= FULL) | flush;
    // A presented partial word blocks input so it cannot grow while stalled.
    assign RX_DST_RDY = (cnt_q <= FULL) & ~(flush & (cnt_q < FULL));
    assign rx_fire    = RX_SRC_RDY & RX_DST_RDY;
    assign tx_fire    = TX_SRC_RDY & TX_DST_RDY;
    assign n_in       = rx_fire ? CW'(popcount(MAX_ITEMS'(RX_VLD))) : '0;
    assign n_out      = tx_fire ? n_avail : '0;
    assign base       = cnt_q - n_out;
    assign cnt_nxt    = base + n_in;
    assign TX_VLD     = TX_SRC_RDY ? ITEMS'(thermometer(int'(n_avail))) : '0;

    for (genvar g = 0; g < ITEMS; g++) begin : g_tx
        assign TX_DATA[g*ITEM_WIDTH +: ITEM_WIDTH] = buf_q[g];
    end

    // Shift out the emitted items, then append the accepted ones behind the rest.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            buf_nxt[i] = '0;
        for (int j = 0; j < DEPTH; j++)
            if (j >= int'(n_out))
                buf_nxt[j - int'(n_out)] = buf_q[j];
        for (int i = 0; i < DEPTH; i++)
            if (i >= int'(base) && i < int'(base) + int'(n_in))
                buf_nxt[i] = RX_DATA[(i - int'(base))*ITEM_WIDTH +: ITEM_WIDTH];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                buf_q[i] <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            buf_q <= buf_nxt;
        end
    end

    mvb_packer_tmo #(
        .ITEMS   (ITEMS),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_tmo (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .cnt_next (cnt_nxt),
        .rx_items (rx_fire && (n_in != '0)),
        .tx_fire  (tx_fire),
        .flush    (flush)
    );

    a_rx_thermometer: assert property (@(posedge CLK) disable iff (!RESET_N)
        RX_SRC_RDY |-> is_thermometer(MAX_ITEMS'(RX_VLD)));

    a_tx_stable: assert property (@(posedge CLK) disable iff (!RESET_N)
        (TX_SRC_RDY && !TX_DST_RDY) |=> ($stable(TX_DATA) && $stable(TX_VLD)));

endmodule
